// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: drives one shared external 1-bit full adder,
// LSB first, one bit per clock, and presents {Cout,Sum} with a one-cycle Done pulse.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             FA_A,
    output logic             FA_B,
    output logic             FA_Cin,
    input  logic             FA_Sum,
    input  logic             FA_Cout
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             running;

    // Adder inputs are gated so the shared adder sees zeros outside RUN.
    assign running = (state == RUN);
    assign FA_A    = running & a_sh[0];
    assign FA_B    = running & b_sh[0];
    assign FA_Cin  = running & carry;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            Sum    <= '0;
            Cout   <= 1'b0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        carry <= Cin;
                        cnt   <= '0;
                        Busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum_sh <= {FA_Sum, sum_sh[WIDTH-1:1]};
                    carry  <= FA_Cout;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // Final bit captured straight into the result so Sum is valid with Done.
                        Sum   <= {FA_Sum, sum_sh[WIDTH-1:1]};
                        Cout  <= FA_Cout;
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: driver pushes expected transactions,
// negedge monitor checks Busy/Done timing, adder drive bits and results.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         FA_A;
    logic         FA_B;
    logic         FA_Cin;
    logic         FA_Sum;
    logic         FA_Cout;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .Start  (Start),
        .A      (A),
        .B      (B),
        .Cin    (Cin),
        .Busy   (Busy),
        .Done   (Done),
        .Sum    (Sum),
        .Cout   (Cout),
        .FA_A   (FA_A),
        .FA_B   (FA_B),
        .FA_Cin (FA_Cin),
        .FA_Sum (FA_Sum),
        .FA_Cout(FA_Cout)
    );

    // The shared full adder
    assign FA_Sum  = FA_A ^ FA_B ^ FA_Cin;
    assign FA_Cout = (FA_A & FA_B) | (FA_Cin & (FA_A ^ FA_B));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           done_edge;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W:0]   res;
    } txn_t;

    txn_t sb[$];

    int   total = 0;
    int   bad = 0;
    int   edge_n = 0;
    int   last_acc = -1000;
    int   accepts = 0;
    logic rst_edge = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at edge %0d: actual=%0h required=%0h", name, edge_n, act, req);
        end
    endfunction

    // One clock of stimulus; the acceptance decision is the model's own.
    task automatic step(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic r);
        txn_t t;
        Start = s;
        A     = a;
        B     = b;
        Cin   = c;
        rst   = r;
        @(posedge clk);
        edge_n++;
        if (r) begin
            sb.delete();
            last_acc = -1000;
            rst_edge = 1'b1;
        end else begin
            rst_edge = 1'b0;
            if (s && (edge_n > last_acc + int'(W))) begin
                last_acc    = edge_n;
                t.done_edge = edge_n + int'(W);
                t.a         = a;
                t.b         = b;
                t.cin       = c;
                t.res       = (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
                sb.push_back(t);
                accepts++;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    // Monitor
    logic [W-1:0]       held_sum = '0;
    logic               held_cout = 1'b0;
    logic               prev_done = 1'b0;
    logic               exp_busy;
    logic               exp_done;
    int                 k;
    longint unsigned    mask;
    longint unsigned    lo;

    always @(negedge clk) begin
        if (edge_n > 0) begin
            if (rst_edge) begin
                held_sum  = '0;
                held_cout = 1'b0;
                chk("rst_busy", 64'(Busy), 64'(0));
                chk("rst_done", 64'(Done), 64'(0));
                chk("rst_sum", 64'(Sum), 64'(0));
                chk("rst_cout", 64'(Cout), 64'(0));
                chk("rst_fa", 64'({FA_A, FA_B, FA_Cin}), 64'(0));
            end
            exp_done = (sb.size() > 0) && (sb[0].done_edge == edge_n);
            exp_busy = (sb.size() > 0) && (edge_n < sb[0].done_edge);
            chk("busy", 64'(Busy), 64'(exp_busy));
            chk("done", 64'(Done), 64'(exp_done));
            if (Done) chk("done_width", 64'(prev_done), 64'(0));
            if (exp_busy) begin
                k    = edge_n - (sb[0].done_edge - int'(W));
                mask = (64'd1 << k) - 64'd1;
                lo   = (64'(sb[0].a) & mask) + (64'(sb[0].b) & mask) + 64'(sb[0].cin);
                chk("fa_a", 64'(FA_A), 64'(sb[0].a[k]));
                chk("fa_b", 64'(FA_B), 64'(sb[0].b[k]));
                chk("fa_cin", 64'(FA_Cin), (lo >> k) & 64'd1);
            end else begin
                chk("fa_idle", 64'({FA_A, FA_B, FA_Cin}), 64'(0));
            end
            if (exp_done) begin
                held_sum  = sb[0].res[W-1:0];
                held_cout = sb[0].res[W];
            end
            chk("sum", 64'(Sum), 64'(held_sum));
            chk("cout", 64'(Cout), 64'(held_cout));
            while ((sb.size() > 0) && (sb[0].done_edge <= edge_n)) void'(sb.pop_front());
            prev_done = Done;
        end
    end

    initial begin
        Start = 1'b0;
        A     = '0;
        B     = '0;
        Cin   = 1'b0;
        rst   = 1'b1;

        step(1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b1, 8'hAA, 8'h55, 1'b1, 1'b1);   // rst beats Start
        idle(2);

        // Basic adds
        step(1'b1, 8'h0F, 8'h01, 1'b0, 1'b0);
        idle(W + 2);
        step(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
        idle(W + 2);
        step(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
        idle(W + 2);

        // Start mid-RUN is ignored
        step(1'b1, 8'h5A, 8'h3C, 1'b1, 1'b0);
        idle(2);
        step(1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
        idle(W + 1);

        // Back-to-back: Start held in the DONE cycle
        step(1'b1, 8'h21, 8'h43, 1'b0, 1'b0);
        idle(W);
        step(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
        idle(W + 2);

        // Reset mid-RUN, then a fresh add
        step(1'b1, 8'h77, 8'h99, 1'b1, 1'b0);
        idle(3);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        idle(2);
        step(1'b1, 8'h80, 8'h80, 1'b1, 1'b0);
        idle(W + 2);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 20000 && accepts < 1040; i++) begin
            step(1'(($urandom % 3) != 0), W'($urandom), W'($urandom), 1'($urandom),
                 1'(($urandom % 500) == 0));
        end
        idle(W + 3);
        chk("drain", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
